// File: rtl/endereco_playback_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// endereco_pkg
// Shared definitions for the PCM playback address controller:
//   - default parameter values for endereco_playback_ctrl
//   - playback state encoding
//   - seek request codes and the fixed button priority resolver
// ---------------------------------------------------------------------------
package endereco_pkg;

   localparam int unsigned ADDR_W_DEF          = 22;
   localparam int unsigned SAMPLES_PER_SEC_DEF = 11025;
   localparam int unsigned STEP_SHORT_S_DEF    = 10;
   localparam int unsigned STEP_LONG_S_DEF     = 30;
   localparam int unsigned TIME_W_DEF          = 9;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PLAY,
      ST_ENDED
   } play_state_t;

   typedef enum logic [2:0] {
      SEEK_NONE,
      SEEK_FWD_LONG,
      SEEK_BACK_LONG,
      SEEK_FWD_SHORT,
      SEEK_BACK_SHORT
   } seek_code_t;

   // Only the highest-priority edge of a cycle survives; the rest are dropped.
   function automatic seek_code_t seek_pick(input logic fwd_long,
                                            input logic back_long,
                                            input logic fwd_short,
                                            input logic back_short);
      if (fwd_long)
         return SEEK_FWD_LONG;
      else if (back_long)
         return SEEK_BACK_LONG;
      else if (fwd_short)
         return SEEK_FWD_SHORT;
      else if (back_short)
         return SEEK_BACK_SHORT;
      else
         return SEEK_NONE;
   endfunction

endpackage

// File: rtl/endereco_playback_ctrl_btn_edge_sync.sv
// ---------------------------------------------------------------------------
// btn_edge_sync
// Two-flop synchroniser followed by a rising-edge detector for one
// asynchronous, level-type push button.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   btn   : raw button level (asynchronous)
//   rise  : one-cycle pulse after a synchronised 0->1 transition
// ---------------------------------------------------------------------------
module btn_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   logic       sync_1;
   logic       sync_2;
   logic       sync_prev;
   logic [2:0] hist_vld;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         sync_prev <= 1'b0;
         hist_vld  <= '0;
      end else begin
         sync_1    <= btn;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
         hist_vld  <= {hist_vld[1:0], 1'b1};
      end
   end

   // sync_prev only holds a real sample once three edges have passed since
   // reset; until then a button already held at release would look like a
   // fresh 0->1 transition, so detection is gated off.
   assign rise = sync_2 & ~sync_prev & hist_vld[2];

endmodule

// File: rtl/endereco_playback_ctrl.sv
// ---------------------------------------------------------------------------
// endereco_playback_ctrl
// Generates the PCM read address for track playback with +/- short and long
// seek buttons, end-of-track detection and optional looping.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   passa_10s, volta_10s  : short forward / backward seek buttons (async level)
//   passa_30s, volta_30s  : long forward / backward seek buttons (async level)
//   count                 : playback enable, one address step per clk
//   current_value         : PCM sample at endereco, 0 marks end of track
//   track_base, track_end : inclusive address window of the current track
//   loop_en               : 1 = wrap to track_base at end, 0 = stop
//   restart               : reload track_base and resume playback
//   endereco              : current read address
//   time_adder            : signed seconds applied by the last good seek
//   time_valid            : one-cycle pulse when time_adder updates
//   end_of_track          : one-cycle pulse on end-of-track detection
// ---------------------------------------------------------------------------
module endereco_playback_ctrl
   import endereco_pkg::*;
#(
   parameter int unsigned ADDR_W          = ADDR_W_DEF,
   parameter int unsigned SAMPLES_PER_SEC = SAMPLES_PER_SEC_DEF,
   parameter int unsigned STEP_SHORT_S    = STEP_SHORT_S_DEF,
   parameter int unsigned STEP_LONG_S     = STEP_LONG_S_DEF,
   parameter int unsigned TIME_W          = TIME_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     passa_10s,
   input  logic                     volta_10s,
   input  logic                     passa_30s,
   input  logic                     volta_30s,
   input  logic                     count,
   input  logic [7:0]               current_value,
   input  logic [ADDR_W-1:0]        track_base,
   input  logic [ADDR_W-1:0]        track_end,
   input  logic                     loop_en,
   input  logic                     restart,
   output logic [ADDR_W-1:0]        endereco,
   output logic signed [TIME_W-1:0] time_adder,
   output logic                     time_valid,
   output logic                     end_of_track
);

   // Seek distances in address units, one bit wider than the address so the
   // window checks below never wrap.
   localparam logic [ADDR_W:0] STEP_SHORT =
      (ADDR_W + 1)'(STEP_SHORT_S * SAMPLES_PER_SEC);
   localparam logic [ADDR_W:0] STEP_LONG =
      (ADDR_W + 1)'(STEP_LONG_S * SAMPLES_PER_SEC);
   localparam logic signed [TIME_W-1:0] SECS_SHORT = TIME_W'(STEP_SHORT_S);
   localparam logic signed [TIME_W-1:0] SECS_LONG  = TIME_W'(STEP_LONG_S);

   play_state_t state, state_n;

   logic [ADDR_W-1:0]        endereco_n;
   logic signed [TIME_W-1:0] time_adder_n;
   logic                     time_valid_n;
   logic                     end_of_track_n;

   logic rise_fwd_long, rise_back_long, rise_fwd_short, rise_back_short;
   seek_code_t seek;

   logic [ADDR_W:0]          addr_ext, base_ext, end_ext;
   logic [ADDR_W:0]          seek_step, fwd_target, back_floor;
   logic                     seek_fwd, seek_ok, end_evt;
   logic signed [TIME_W-1:0] seek_secs;
   logic [ADDR_W-1:0]        seek_addr;

   // ---------------------------------------------------------------- buttons
   btn_edge_sync u_sync_passa_30s (
      .clk   (clk),
      .reset (reset),
      .btn   (passa_30s),
      .rise  (rise_fwd_long)
   );

   btn_edge_sync u_sync_volta_30s (
      .clk   (clk),
      .reset (reset),
      .btn   (volta_30s),
      .rise  (rise_back_long)
   );

   btn_edge_sync u_sync_passa_10s (
      .clk   (clk),
      .reset (reset),
      .btn   (passa_10s),
      .rise  (rise_fwd_short)
   );

   btn_edge_sync u_sync_volta_10s (
      .clk   (clk),
      .reset (reset),
      .btn   (volta_10s),
      .rise  (rise_back_short)
   );

   assign seek = seek_pick(rise_fwd_long, rise_back_long,
                           rise_fwd_short, rise_back_short);

   // ------------------------------------------------------- seek evaluation
   always_comb begin
      seek_step = '0;
      seek_fwd  = 1'b0;
      seek_secs = '0;
      unique case (seek)
         SEEK_FWD_LONG: begin
            seek_step = STEP_LONG;
            seek_fwd  = 1'b1;
            seek_secs = SECS_LONG;
         end
         SEEK_BACK_LONG: begin
            seek_step = STEP_LONG;
            seek_secs = -SECS_LONG;
         end
         SEEK_FWD_SHORT: begin
            seek_step = STEP_SHORT;
            seek_fwd  = 1'b1;
            seek_secs = SECS_SHORT;
         end
         SEEK_BACK_SHORT: begin
            seek_step = STEP_SHORT;
            seek_secs = -SECS_SHORT;
         end
         default: ;
      endcase
   end

   assign addr_ext   = {1'b0, endereco};
   assign base_ext   = {1'b0, track_base};
   assign end_ext    = {1'b0, track_end};
   assign fwd_target = addr_ext + seek_step;
   // Backward check is "addr >= base + step" rather than "addr - step >= base"
   // so a step larger than the address cannot underflow.
   assign back_floor = base_ext + seek_step;

   assign seek_ok = (seek != SEEK_NONE) &&
                    (seek_fwd ? (fwd_target <= end_ext) : (addr_ext >= back_floor));

   assign seek_addr = seek_fwd ? fwd_target[ADDR_W-1:0]
                               : (endereco - seek_step[ADDR_W-1:0]);

   assign end_evt = count && ((current_value == 8'd0) || (endereco == track_end));

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         endereco     <= '0;
         time_adder   <= '0;
         time_valid   <= 1'b0;
         end_of_track <= 1'b0;
      end else begin
         state        <= state_n;
         endereco     <= endereco_n;
         time_adder   <= time_adder_n;
         time_valid   <= time_valid_n;
         end_of_track <= end_of_track_n;
      end
   end

   always_comb begin
      state_n        = state;
      endereco_n     = endereco;
      time_adder_n   = time_adder;
      time_valid_n   = 1'b0;
      end_of_track_n = 1'b0;

      if (restart) begin
         state_n    = ST_PLAY;
         endereco_n = track_base;
      end else begin
         unique case (state)
            ST_IDLE: begin
               state_n    = ST_PLAY;
               endereco_n = track_base;
            end
            ST_PLAY: begin
               if (end_evt) begin
                  end_of_track_n = 1'b1;
                  if (loop_en)
                     endereco_n = track_base;
                  else
                     state_n = ST_ENDED;
               end else if (seek != SEEK_NONE) begin
                  // Any seek request, accepted or not, takes the cycle's step.
                  if (seek_ok) begin
                     endereco_n   = seek_addr;
                     time_adder_n = seek_secs;
                     time_valid_n = 1'b1;
                  end
               end else if (count) begin
                  endereco_n = endereco + ADDR_W'(1);
               end
            end
            ST_ENDED: ;
            default: begin
               state_n    = ST_IDLE;
               endereco_n = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_endereco_playback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_endereco_playback_ctrl
// Directed bench for endereco_playback_ctrl with SAMPLES_PER_SEC=4,
// track window 100..400. A timeline-level reference model predicts every
// output each cycle; hand-computed literals pin key points of the scenario.
// ---------------------------------------------------------------------------
module tb_endereco_playback_ctrl;

   localparam int unsigned AW  = 22;
   localparam int unsigned TW  = 9;
   localparam int unsigned SPS = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 passa_10s, volta_10s, passa_30s, volta_30s;
   logic                 count, loop_en, restart;
   logic [7:0]           current_value;
   logic [AW-1:0]        track_base, track_end, endereco;
   logic signed [TW-1:0] time_adder;
   logic                 time_valid, end_of_track;

   int n_checks = 0;
   int n_err    = 0;
   bit run_cmp  = 1'b0;

   endereco_playback_ctrl #(
      .ADDR_W          (AW),
      .SAMPLES_PER_SEC (SPS),
      .STEP_SHORT_S    (10),
      .STEP_LONG_S     (30),
      .TIME_W          (TW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .passa_10s     (passa_10s),
      .volta_10s     (volta_10s),
      .passa_30s     (passa_30s),
      .volta_30s     (volta_30s),
      .count         (count),
      .current_value (current_value),
      .track_base    (track_base),
      .track_end     (track_end),
      .loop_en       (loop_en),
      .restart       (restart),
      .endereco      (endereco),
      .time_adder    (time_adder),
      .time_valid    (time_valid),
      .end_of_track  (end_of_track)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ----------------------------------------------------- reference model
   // Button index order is the priority order: passa_30s, volta_30s,
   // passa_10s, volta_10s. A press is honoured on the third edge after the
   // first edge that samples it high, provided the edge before that sampled
   // it low after reset.
   localparam int PH_IDLE  = 0;
   localparam int PH_PLAY  = 1;
   localparam int PH_ENDED = 2;

   int   secs[4] = '{30, 30, 10, 10};
   int   dir[4]  = '{1, -1, 1, -1};
   int   m_addr  = 0;
   int   m_tadd  = 0;
   int   m_tv    = 0;
   int   m_eot   = 0;
   int   m_phase = PH_IDLE;
   int   m_edges = 0;
   int   pick;
   int   tgt;
   bit   lv[4][3];
   logic [3:0] btn_now;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_addr  = 0;
         m_tadd  = 0;
         m_tv    = 0;
         m_eot   = 0;
         m_phase = PH_IDLE;
         m_edges = 0;
         for (int b = 0; b < 4; b++)
            for (int j = 0; j < 3; j++)
               lv[b][j] = 1'b0;
      end else begin
         btn_now = {volta_10s, passa_10s, volta_30s, passa_30s};
         m_edges++;
         pick = -1;
         for (int b = 0; b < 4; b++)
            if (pick < 0 && m_edges >= 4 && lv[b][1] && !lv[b][2])
               pick = b;
         for (int b = 0; b < 4; b++) begin
            lv[b][2] = lv[b][1];
            lv[b][1] = lv[b][0];
            lv[b][0] = btn_now[b];
         end
         m_tv  = 0;
         m_eot = 0;
         if (restart) begin
            m_addr  = int'(track_base);
            m_phase = PH_PLAY;
         end else if (m_phase == PH_IDLE) begin
            m_addr  = int'(track_base);
            m_phase = PH_PLAY;
         end else if (m_phase == PH_PLAY) begin
            if (count && (current_value == 8'd0 || m_addr == int'(track_end))) begin
               m_eot = 1;
               if (loop_en) m_addr = int'(track_base);
               else         m_phase = PH_ENDED;
            end else if (pick >= 0) begin
               tgt = m_addr + dir[pick] * secs[pick] * int'(SPS);
               if (tgt >= int'(track_base) && tgt <= int'(track_end)) begin
                  m_addr = tgt;
                  m_tadd = dir[pick] * secs[pick];
                  m_tv   = 1;
               end
            end else if (count) begin
               m_addr = m_addr + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("cyc_endereco",     int'(endereco),     m_addr);
         chk("cyc_time_adder",   int'(time_adder),   m_tadd);
         chk("cyc_time_valid",   int'(time_valid),   m_tv);
         chk("cyc_end_of_track", int'(end_of_track), m_eot);
      end
   end

   // --------------------------------------------------------- stimulus
   task automatic set_btn(input logic [3:0] m);
      {volta_10s, passa_10s, volta_30s, passa_30s} = m;
   endtask

   task automatic press(input logic [3:0] m);
      set_btn(m);
      repeat (4) @(negedge clk);
      set_btn(4'b0000);
      repeat (2) @(negedge clk);
   endtask

   task automatic run_to(input int target, input int budget);
      for (int i = 0; i < budget && m_addr != target; i++)
         @(negedge clk);
      chk("run_to_reached", m_addr, target);
   endtask

   task automatic do_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset         = 1'b1;
      set_btn(4'b0000);
      count         = 1'b1;
      loop_en       = 1'b1;
      restart       = 1'b0;
      current_value = 8'd11;
      track_base    = AW'(100);
      track_end     = AW'(400);
      #2 run_cmp = 1'b1;

      // reset state, load, increment
      repeat (2) @(negedge clk);
      chk("rst_endereco", int'(endereco), 0);
      chk("rst_time_valid", int'(time_valid), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("first_load", int'(endereco), 100);
      @(negedge clk);
      chk("first_inc", int'(endereco), 101);
      @(negedge clk);
      chk("second_inc", int'(endereco), 102);

      // forward short seek latency from 150
      run_to(150, 100);
      count = 1'b0;
      passa_10s = 1'b1;
      repeat (2) @(negedge clk);
      chk("seek_not_yet", int'(endereco), 150);
      @(negedge clk);
      chk("seek10_addr", int'(endereco), 190);
      chk("seek10_tv", int'(time_valid), 1);
      chk("seek10_tadd", int'(time_adder), 10);
      passa_10s = 1'b0;
      @(negedge clk);
      chk("seek10_tv_drop", int'(time_valid), 0);

      // rejected backward seek, simultaneous edges
      do_restart();
      chk("restart_load", int'(endereco), 100);
      count = 1'b1;
      run_to(120, 100);
      count = 1'b0;
      press(4'b0010);
      chk("back30_reject_addr", int'(endereco), 120);
      chk("back30_reject_tadd", int'(time_adder), 10);
      set_btn(4'b1001);
      repeat (3) @(negedge clk);
      chk("prio_fwd30_addr", int'(endereco), 240);
      chk("prio_fwd30_tadd", int'(time_adder), 30);
      repeat (6) @(negedge clk);
      chk("held_one_seek", int'(endereco), 240);
      set_btn(4'b0000);
      repeat (2) @(negedge clk);
      press(4'b0110);
      chk("prio_back30_addr", int'(endereco), 120);
      chk("prio_back30_tadd", int'(time_adder), -30);

      // forward window edge
      press(4'b0001);
      press(4'b0001);
      chk("fwd_360", int'(endereco), 360);
      press(4'b0001);
      chk("fwd_over_end", int'(endereco), 360);
      press(4'b0100);
      chk("fwd_exact_end", int'(endereco), 400);
      chk("fwd_exact_tadd", int'(time_adder), 10);

      // backward window edge
      do_restart();
      count = 1'b1;
      run_to(140, 100);
      count = 1'b0;
      press(4'b1000);
      chk("back_exact_base", int'(endereco), 100);
      chk("back_exact_tadd", int'(time_adder), -10);
      press(4'b1000);
      chk("back_below_base", int'(endereco), 100);

      // end of track by sample value, looping
      count = 1'b1;
      repeat (3) @(negedge clk);
      current_value = 8'd0;
      @(negedge clk);
      chk("loop_addr", int'(endereco), 100);
      chk("loop_eot", int'(end_of_track), 1);
      current_value = 8'd11;
      @(negedge clk);
      chk("loop_resume", int'(endereco), 101);

      // end event beats a seek landing on the same edge
      count = 1'b0;
      passa_10s = 1'b1;
      repeat (2) @(negedge clk);
      count = 1'b1;
      current_value = 8'd0;
      @(negedge clk);
      chk("end_beats_seek_addr", int'(endereco), 100);
      chk("end_beats_seek_tv", int'(time_valid), 0);
      current_value = 8'd11;
      passa_10s = 1'b0;
      @(negedge clk);

      // end at track_end, stop
      loop_en = 1'b0;
      run_to(400, 400);
      @(negedge clk);
      chk("stop_end_addr", int'(endereco), 400);
      chk("stop_end_eot", int'(end_of_track), 1);
      repeat (3) @(negedge clk);
      chk("ended_ignores_count", int'(endereco), 400);
      press(4'b1000);
      chk("ended_ignores_seek", int'(endereco), 400);
      chk("ended_tadd_hold", int'(time_adder), -10);

      // restart from ENDED, then stop via sample value
      do_restart();
      chk("ended_restart", int'(endereco), 100);
      @(negedge clk);
      chk("restart_inc", int'(endereco), 101);
      current_value = 8'd0;
      @(negedge clk);
      chk("stop_cv_addr", int'(endereco), 101);
      chk("stop_cv_eot", int'(end_of_track), 1);
      current_value = 8'd11;
      repeat (2) @(negedge clk);
      chk("stop_cv_hold", int'(endereco), 101);

      // asynchronous reset mid-count, button held across release
      do_restart();
      loop_en = 1'b1;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("async_rst_addr", int'(endereco), 0);
      chk("async_rst_tadd", int'(time_adder), 0);
      chk("async_rst_tv", int'(time_valid), 0);
      chk("async_rst_eot", int'(end_of_track), 0);
      passa_10s = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      chk("held_at_release_addr", int'(endereco), 107);
      chk("held_at_release_tadd", int'(time_adder), 0);
      passa_10s = 1'b0;
      repeat (3) @(negedge clk);

      run_cmp = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/endereco_playback_ctrl.md
ENDERECO_PLAYBACK_CTRL -- requirements
Module: endereco_playback_ctrl

Interface
REQ-001 Parameter ADDR_W, default 22, width of the PCM memory address.
REQ-002 Parameter SAMPLES_PER_SEC, default 11025, address increments per second of audio.
REQ-003 Parameter STEP_SHORT_S, default 10, short seek in seconds; STEP_LONG_S, default 30, long seek in seconds.
REQ-004 Parameter TIME_W, default 9, width of signed time_adder.
REQ-005 clk  input  1  single system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 passa_10s, volta_10s, passa_30s, volta_30s  input  1 each  seek buttons, level, asynchronous to logic.
REQ-008 count  input  1  playback enable; address advances one per clk while high in PLAY.
REQ-009 current_value  input  8  PCM sample at endereco; 0 marks end of track.
REQ-010 track_base, track_end  input  ADDR_W each  inclusive address window of current track; stable during PLAY.
REQ-011 loop_en  input  1  1 = wrap to track_base at end of track; 0 = stop.
REQ-012 restart  input  1  synchronous pulse, reload track_base and resume PLAY.
REQ-013 endereco  output  ADDR_W  current read address.
REQ-014 time_adder  output  TIME_W signed  seconds actually applied by the last seek (+/-STEP_SHORT_S or +/-STEP_LONG_S).
REQ-015 time_valid  output  1  one-cycle pulse when time_adder updates.
REQ-016 end_of_track  output  1  one-cycle pulse on end-of-track detection.

Function
REQ-017 States: IDLE, PLAY, ENDED; exactly one active.
REQ-018 IDLE: next edge loads endereco <= track_base, goes PLAY.
REQ-019 PLAY with count=1 and no seek/end event: endereco <= endereco+1.
REQ-020 PLAY with count=0: endereco holds; seeks still honoured.
REQ-021 Each button passes a 2-flop synchroniser then rising-edge detect; a held button yields one seek.
REQ-022 Seek applied on the clk edge after edge detect: 3 clk edges from button rise to endereco change.
REQ-023 Forward seek of S seconds: if endereco + S*SAMPLES_PER_SEC <= track_end, add it; else no change, no time_valid.
REQ-024 Backward seek: if endereco - S*SAMPLES_PER_SEC >= track_base, subtract; else no change, no time_valid.
REQ-025 Comparisons done in ADDR_W+1 bits; no wrap-around of endereco ever from a seek.
REQ-026 Simultaneous edges same cycle: priority passa_30s > volta_30s > passa_10s > volta_10s; lower-priority edges dropped.
REQ-027 Seek in a cycle suppresses that cycle's count increment.
REQ-028 Successful seek: time_adder <= +/-S, time_valid=1 for that cycle; else time_adder holds.
REQ-029 End event in PLAY: (count=1 and current_value==0) or (count=1 and endereco==track_end).
REQ-030 End event, loop_en=1: endereco <= track_base, stay PLAY, end_of_track pulse.
REQ-031 End event, loop_en=0: endereco holds, go ENDED, end_of_track pulse.
REQ-032 End event and seek same cycle: end event wins, seek dropped.
REQ-033 ENDED: ignore count and seeks; leave only via restart or reset.
REQ-034 restart in any state: endereco <= track_base, PLAY; overrides seek and end event.

Reset
REQ-035 reset=1 asynchronously forces IDLE, endereco=0, time_adder=0, time_valid=0, end_of_track=0, synchroniser/edge flops=0.
REQ-036 Reset released mid-seek or mid-button-press: no seek issued for a button already high at release.

Structure
REQ-037 Package endereco_pkg holds state encoding, default parameter values and seek-priority codes.
REQ-038 One sub-module btn_edge_sync (2-flop sync + rising-edge detect), instanced per button.
REQ-039 Step constants S*SAMPLES_PER_SEC computed at elaboration; must fit ADDR_W.

Verification (SAMPLES_PER_SEC=4, base=100, end=400, current_value=11)
REQ-040 Reset, count=1 -> endereco 0, then 100, then +1 per clk.
REQ-041 endereco=150, passa_10s pulse -> endereco 190 after 3 edges, time_adder=+10, time_valid 1 cycle.
REQ-042 endereco=120, volta_30s -> no change, no time_valid; passa_30s+volta_10s same cycle -> +120 only.
REQ-043 current_value=0, loop_en=1 -> endereco 100, end_of_track pulse; loop_en=0 -> ENDED, endereco holds, count ignored.
REQ-044 ENDED, restart pulse -> endereco 100, PLAY resumes incrementing.
REQ-045 reset asserted mid-count -> outputs 0 immediately, without clk edge.
